// File: rtl/wol_pm_ctrl_if.sv
// Wake-on-LAN power-management control bundle.
// Groups the host, receive-path and detector signals of wol_pm_ctrl.
// The master side (host / stimulus) drives the requests and samples the
// status; the slave side is the sequencer itself.
interface wol_pm_ctrl_if;
  logic       clk_en;
  logic       sleep_req;
  logic       magic_en;
  logic       rx_dv;
  logic       magic_det;
  logic       host_wake;
  logic       irq_clr;
  logic       det_arm;
  logic       det_clr;
  logic       rx_fwd_en;
  logic       sleep_ack;
  logic       wake_irq;
  logic [2:0] wake_cause;
  logic [1:0] pm_state;

  modport master (
    output clk_en, sleep_req, magic_en, rx_dv, magic_det, host_wake, irq_clr,
    input  det_arm, det_clr, rx_fwd_en, sleep_ack, wake_irq, wake_cause, pm_state
  );

  modport slave (
    input  clk_en, sleep_req, magic_en, rx_dv, magic_det, host_wake, irq_clr,
    output det_arm, det_clr, rx_fwd_en, sleep_ack, wake_irq, wake_cause, pm_state
  );
endinterface

// File: rtl/wol_pm_ctrl.sv
// Wake-on-LAN power-management sequencer, TSE MAC receive clock domain.
// Drains the current frame and a clean idle gap before sleeping, arms the
// magic-packet detector while asleep, and leaves sleep on a magic hit or a
// host wake, latching a sticky interrupt with the wake cause.
// Optional: define WOL_WAKE_TIMER_EN to add a timeout wake (cause bit2);
// without it wake_cause[2] is always 0 and no timer exists.
module wol_pm_ctrl #(
  parameter int IDLE_GAP = 12
`ifdef WOL_WAKE_TIMER_EN
  , parameter int WAKE_TIMEOUT = 1000000
`endif
) (
  input logic          CORETSE_AHBii0,
  input logic          CORETSE_AHBl0II,
  wol_pm_ctrl_if.slave pm
);

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'b00,
    ST_DRAIN  = 2'b01,
    ST_SLEEP  = 2'b10,
    ST_WAKE   = 2'b11
  } pm_state_t;

  localparam logic [7:0] LP_GAP = 8'(IDLE_GAP);

  pm_state_t  r_state;
  logic [7:0] r_idleCnt;
  logic       r_wakeIrq;
  logic [2:0] r_wakeCause;

  logic [7:0] w_idleNext;
  logic       w_gapMet;
  logic       w_magicHit;
  logic       w_timerHit;
  logic [2:0] w_wakeEvt;
  logic       w_wakeTaken;

  // Idle-gap counter candidate: a valid beat restarts the gap, idle beats count up and saturate
  assign w_idleNext = pm.rx_dv ? 8'd0 :
                      ((r_idleCnt >= LP_GAP) ? LP_GAP : (r_idleCnt + 8'd1));
  assign w_gapMet   = !pm.rx_dv && (w_idleNext == LP_GAP);

  assign w_magicHit = pm.magic_det & pm.magic_en;

`ifdef WOL_WAKE_TIMER_EN
  localparam logic [23:0] LP_TIMEOUT_M1 = 24'(WAKE_TIMEOUT - 1);

  logic [23:0] r_timer;

  assign w_timerHit = (r_state == ST_SLEEP) && (r_timer == LP_TIMEOUT_M1);

  // Sleep timer: held at zero outside SLEEP so it restarts on every entry
  always_ff @(posedge CORETSE_AHBii0 or posedge CORETSE_AHBl0II) begin
    if (CORETSE_AHBl0II) begin
      r_timer <= 24'd0;
    end else if (pm.clk_en) begin
      if (r_state == ST_SLEEP) begin
        r_timer <= r_timer + 24'd1;
      end else begin
        r_timer <= 24'd0;
      end
    end
  end
`else
  assign w_timerHit = 1'b0;
`endif

  // A dropped sleep request outranks every wake source, so only count a wake when still requested
  assign w_wakeEvt   = {w_timerHit, pm.host_wake, w_magicHit};
  assign w_wakeTaken = (r_state == ST_SLEEP) && pm.sleep_req && (|w_wakeEvt);

  // Sequencer: frame-boundary-safe entry to and exit from sleep
  always_ff @(posedge CORETSE_AHBii0 or posedge CORETSE_AHBl0II) begin
    if (CORETSE_AHBl0II) begin
      r_state   <= ST_ACTIVE;
      r_idleCnt <= 8'd0;
    end else if (pm.clk_en) begin
      case (r_state)
        ST_ACTIVE: begin
          if (pm.sleep_req) begin
            r_state   <= ST_DRAIN;
            r_idleCnt <= 8'd0;
          end
        end
        ST_DRAIN: begin
          if (!pm.sleep_req) begin
            r_state <= ST_ACTIVE;
          end else begin
            r_idleCnt <= w_idleNext;
            if (w_gapMet) begin
              r_state <= ST_SLEEP;
            end
          end
        end
        ST_SLEEP: begin
          if (!pm.sleep_req) begin
            r_state <= ST_ACTIVE;
          end else if (w_wakeTaken) begin
            r_state <= ST_WAKE;
          end
        end
        ST_WAKE: begin
          if (!pm.sleep_req && !pm.rx_dv) begin
            r_state <= ST_ACTIVE;
          end
        end
        default: begin
          r_state <= ST_ACTIVE;
        end
      endcase
    end
  end

  // Sticky wake interrupt and cause; a new wake beats a coincident clear
  always_ff @(posedge CORETSE_AHBii0 or posedge CORETSE_AHBl0II) begin
    if (CORETSE_AHBl0II) begin
      r_wakeIrq   <= 1'b0;
      r_wakeCause <= 3'b000;
    end else if (pm.clk_en) begin
      if (w_wakeTaken) begin
        r_wakeIrq   <= 1'b1;
        r_wakeCause <= pm.irq_clr ? w_wakeEvt : (r_wakeCause | w_wakeEvt);
      end else if (pm.irq_clr) begin
        r_wakeIrq   <= 1'b0;
        r_wakeCause <= 3'b000;
      end
    end
  end

  assign pm.pm_state   = r_state;
  assign pm.rx_fwd_en  = (r_state == ST_ACTIVE) || (r_state == ST_DRAIN);
  assign pm.det_clr    = (r_state != ST_SLEEP);
  assign pm.det_arm    = pm.magic_en && (r_state == ST_SLEEP);
  assign pm.sleep_ack  = (r_state == ST_SLEEP);
  assign pm.wake_irq   = r_wakeIrq;
  assign pm.wake_cause = r_wakeCause;

endmodule
